reg_bank_arbiter: RTL and testbench
===================================

REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, as the register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 3, as the register address width (8 registers).
REQ-003 The block SHALL have the following ports; clock and reset are fixed: one clock, reset synchronous and active-high.
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- c_req  in  1  C-latch writeback request
- c_addr  in  ADDR_W  C-latch target register
- c_data  in  DATA_W  C-latch write data
- c_gnt  out  1  C-latch grant pulse
- in0_req / in0_addr / in0_data  in  1 / ADDR_W / DATA_W  bus input 0 request, target, data
- in0_gnt  out  1  input 0 grant pulse
- in1_req / in1_addr / in1_data  in  1 / ADDR_W / DATA_W  bus input 1 request, target, data
- in1_gnt  out  1  input 1 grant pulse
- bank_ready  in  1  register bank accepts a write this cycle
- wr_en  out  1  register bank write strobe
- wr_addr  out  ADDR_W  register bank write address
- wr_data  out  DATA_W  register bank write data
- busy  out  1  high when the FSM is not in IDLE
- wr_count  out  8  completed-write counter

Function
REQ-004 The FSM SHALL have states IDLE, GRANT and WRITE.
REQ-005 In IDLE with any request high, the FSM SHALL select one winner, register its addr/data, and go to GRANT on the next edge; with no request it SHALL remain in IDLE.
REQ-006 c_req SHALL always win over in0_req and in1_req.
REQ-007 In GRANT, exactly the winner's gnt SHALL be high for that single cycle; the FSM SHALL then go to WRITE.
REQ-008 In WRITE, wr_en SHALL be high with the registered addr/data, and the FSM SHALL stay in WRITE until bank_ready is high.
REQ-009 On the WRITE cycle with bank_ready high, the FSM SHALL return to IDLE, and wr_count SHALL increment modulo 256 (255 -> 0).
REQ-010 Latency: a request sampled in IDLE at cycle N SHALL give gnt at N+1 and wr_en at N+2 at the earliest.
REQ-011 A requester SHALL hold req, addr and data stable until its gnt; addr/data are captured at the IDLE edge, so changes after capture SHALL have no effect.
REQ-012 Requests arriving while in GRANT or WRITE SHALL be ignored until the next IDLE cycle; there SHALL be no lost-grant condition as long as req is held.
REQ-013 A requester that drops req before being granted SHALL not be granted.
REQ-014 At most one gnt SHALL be high in any cycle; wr_en SHALL be low outside WRITE.

Reset
REQ-015 With rst high at a clock edge, the FSM SHALL enter IDLE, including mid-GRANT or mid-WRITE (a pending write is aborted with no wr_en).
REQ-016 Reset values SHALL be: all gnt = 0, wr_en = 0, wr_addr = 0, wr_data = 0, busy = 0, wr_count = 0, round-robin pointer = in0 favoured.

Configuration
REQ-017 With macro REG_BANK_ARB_RR_EN defined, in0 and in1 SHALL be arbitrated round-robin: after in0 is granted in1 is favoured, after in1 is granted in0 is favoured, and a C grant leaves the pointer unchanged.
REQ-018 Without REG_BANK_ARB_RR_EN, the priority SHALL be fixed at C > in0 > in1, and no pointer register SHALL exist.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding (IDLE = 2'd0, GRANT = 2'd1, WRITE = 2'd2) and the requester-ID constants (REQ_C, REQ_IN0, REQ_IN1).
REQ-020 Winner selection SHALL be a sub-module, reg_bank_arb_select: a combinational priority/round-robin picker taking the three req signals and the pointer, and returning a one-hot winner.

Verification
REQ-021 Single C write: c_req = 1, c_addr = 5, c_data = 16'hFFFF, bank_ready = 1 -> c_gnt at N+1, then wr_en with wr_addr = 5, wr_data = 16'hFFFF at N+2, and wr_count = 1.
REQ-022 Simultaneous requests: c = 16'hFFFF @1, in0 = 16'h0F0F @2, in1 = 16'hF0F0 @3, all held -> order C, in0, in1 with RR on; with RR off, C, in0, in1 also; 3 writes, each 3 cycles apart.
REQ-023 RR fairness: in0 and in1 both held continuously over 4 grants -> RR on: in0, in1, in0, in1; RR off: in0 ×4.
REQ-024 Backpressure: bank_ready = 0 for 5 cycles during WRITE -> wr_en held with stable addr/data for 6 cycles, and wr_count increments once.
REQ-025 Reset mid-WRITE: rst = 1 while in WRITE with in1 pending -> next cycle all outputs at reset values, and in1 is re-granted after rst drops.
REQ-026 Wrap: 256 completed writes -> wr_count = 0.

Source files
------------

// File: rtl/reg_bank_arbiter_pkg.sv
// reg_bank_arbiter_pkg: FSM state encoding and requester IDs (bit positions in the one-hot winner).
package reg_bank_arbiter_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      WRITE = 2'd2
   } state_t;
   localparam int REQ_C   = 2;
   localparam int REQ_IN0 = 1;
   localparam int REQ_IN1 = 0;
endpackage

// File: rtl/reg_bank_arb_select.sv
// reg_bank_arb_select: one-hot winner picker; C always wins, i_ptr high favours in1 over in0.
module reg_bank_arb_select
   import reg_bank_arbiter_pkg::*;
(
   input  logic       i_c_req,
   input  logic       i_in0_req,
   input  logic       i_in1_req,
   input  logic       i_ptr,
   output logic [2:0] o_win
);
   assign o_win[REQ_C]   = i_c_req;
   assign o_win[REQ_IN0] = !i_c_req && i_in0_req && (!i_ptr || !i_in1_req);
   assign o_win[REQ_IN1] = !i_c_req && i_in1_req && (i_ptr || !i_in0_req);
endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: three-requester register-bank write arbiter (IDLE -> GRANT -> WRITE).
// Define REG_BANK_ARB_RR_EN for round-robin between in0/in1; otherwise fixed C > in0 > in1.
module reg_bank_arbiter
   import reg_bank_arbiter_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c_req,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_data,
   output logic              c_gnt,
   input  logic              in0_req,
   input  logic [ADDR_W-1:0] in0_addr,
   input  logic [DATA_W-1:0] in0_data,
   output logic              in0_gnt,
   input  logic              in1_req,
   input  logic [ADDR_W-1:0] in1_addr,
   input  logic [DATA_W-1:0] in1_data,
   output logic              in1_gnt,
   input  logic              bank_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              busy,
   output logic [7:0]        wr_count
);
   state_t            r_state, w_next;
   logic [2:0]        r_win, w_win;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [7:0]        r_count;
   logic              w_ptr, w_take;

   reg_bank_arb_select u_sel (
      .i_c_req   (c_req),
      .i_in0_req (in0_req),
      .i_in1_req (in1_req),
      .i_ptr     (w_ptr),
      .o_win     (w_win)
   );

   assign w_take = (r_state == IDLE) && (|w_win);

`ifdef REG_BANK_ARB_RR_EN
   logic r_ptr;
   // A C grant leaves the in0/in1 preference untouched
   always_ff @(posedge clk) begin
      if (rst) r_ptr <= 1'b0;
      else if (w_take && !w_win[REQ_C]) r_ptr <= w_win[REQ_IN0];
   end
   assign w_ptr = r_ptr;
`else
   assign w_ptr = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_win   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_take) begin
            r_win  <= w_win;
            r_addr <= w_win[REQ_C] ? c_addr : w_win[REQ_IN0] ? in0_addr : in1_addr;
            r_data <= w_win[REQ_C] ? c_data : w_win[REQ_IN0] ? in0_data : in1_data;
         end
         if (r_state == WRITE && bank_ready) r_count <= r_count + 8'd1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_take ? GRANT : IDLE;
         GRANT:   w_next = WRITE;
         WRITE:   w_next = bank_ready ? IDLE : WRITE;
         default: w_next = IDLE;
      endcase
   end

   assign c_gnt    = (r_state == GRANT) && r_win[REQ_C];
   assign in0_gnt  = (r_state == GRANT) && r_win[REQ_IN0];
   assign in1_gnt  = (r_state == GRANT) && r_win[REQ_IN1];
   assign wr_en    = (r_state == WRITE);
   assign wr_addr  = r_addr;
   assign wr_data  = r_data;
   assign busy     = (r_state != IDLE);
   assign wr_count = r_count;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed vectors for latency, priority, round-robin, backpressure, reset and wrap.
module tb_reg_bank_arbiter;
   logic        clk = 1'b0, rst = 1'b1;
   logic        c_req, in0_req, in1_req, bank_ready;
   logic [2:0]  c_addr, in0_addr, in1_addr, wr_addr;
   logic [15:0] c_data, in0_data, in1_data, wr_data;
   logic        c_gnt, in0_gnt, in1_gnt, wr_en, busy;
   logic [7:0]  wr_count;
   logic [2:0]  gnt;
   logic [2:0]  exp3 [4];
   int          n_chk = 0, n_pass = 0, cyc = 0, t_g = 0, g0 = 0, gc = 0, n = 0;
   logic [2:0]  seen;

   assign gnt = {c_gnt, in0_gnt, in1_gnt};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   reg_bank_arbiter dut (
      .clk(clk), .rst(rst),
      .c_req(c_req), .c_addr(c_addr), .c_data(c_data), .c_gnt(c_gnt),
      .in0_req(in0_req), .in0_addr(in0_addr), .in0_data(in0_data), .in0_gnt(in0_gnt),
      .in1_req(in1_req), .in1_addr(in1_addr), .in1_data(in1_data), .in1_gnt(in1_gnt),
      .bank_ready(bank_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .wr_count(wr_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for a grant, checks it, clears the reqs in drop, then checks the first WRITE cycle
   task automatic expect_grant(input string tag, input logic [2:0] g, input logic [2:0] a,
                               input logic [15:0] d, input logic [2:0] drop);
      int k = 0;
      while (gnt == 3'b000 && k < 12) begin
         tick();
         k++;
      end
      t_g = cyc;
      check({tag, " gnt"}, 32'(gnt), 32'(g));
      if (drop[2]) c_req = 1'b0;
      if (drop[1]) in0_req = 1'b0;
      if (drop[0]) in1_req = 1'b0;
      tick();
      check({tag, " wr_en"}, 32'(wr_en), 32'd1);
      check({tag, " wr_addr"}, 32'(wr_addr), 32'(a));
      check({tag, " wr_data"}, 32'(wr_data), 32'(d));
   endtask

   initial begin
      {c_req, in0_req, in1_req} = 3'b000;
      {c_addr, in0_addr, in1_addr} = '0;
      {c_data, in0_data, in1_data} = '0;
      bank_ready = 1'b1;
      tick();
      tick();
      check("rst gnt", 32'(gnt), 32'd0);
      check("rst wr_en", 32'(wr_en), 32'd0);
      check("rst wr_addr", 32'(wr_addr), 32'd0);
      check("rst wr_data", 32'(wr_data), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst count", 32'(wr_count), 32'd0);
      rst = 1'b0;
      // single C write with exact latency
      c_req = 1'b1; c_addr = 3'd5; c_data = 16'hFFFF;
      tick();
      check("t1 gnt", 32'(gnt), 32'b100);
      check("t1 busy", 32'(busy), 32'd1);
      check("t1 no wr_en in grant", 32'(wr_en), 32'd0);
      c_req = 1'b0;
      tick();
      check("t1 wr_en", 32'(wr_en), 32'd1);
      check("t1 wr_addr", 32'(wr_addr), 32'd5);
      check("t1 wr_data", 32'(wr_data), 32'hFFFF);
      tick();
      check("t1 wr_en off", 32'(wr_en), 32'd0);
      check("t1 count", 32'(wr_count), 32'd1);
      // simultaneous requests
      c_req = 1'b1;   c_addr = 3'd1;   c_data = 16'hFFFF;
      in0_req = 1'b1; in0_addr = 3'd2; in0_data = 16'h0F0F;
      in1_req = 1'b1; in1_addr = 3'd3; in1_data = 16'hF0F0;
      expect_grant("t2 c", 3'b100, 3'd1, 16'hFFFF, 3'b100);
      g0 = t_g;
      expect_grant("t2 in0", 3'b010, 3'd2, 16'h0F0F, 3'b010);
      check("t2 gap c-in0", t_g - g0, 3);
      g0 = t_g;
      expect_grant("t2 in1", 3'b001, 3'd3, 16'hF0F0, 3'b001);
      check("t2 gap in0-in1", t_g - g0, 3);
      tick();
      check("t2 count", 32'(wr_count), 32'd4);
      check("t2 idle", 32'(busy), 32'd0);
      // in0/in1 held over four grants
`ifdef REG_BANK_ARB_RR_EN
      exp3 = '{3'b010, 3'b001, 3'b010, 3'b001};
`else
      exp3 = '{3'b010, 3'b010, 3'b010, 3'b010};
`endif
      in0_req = 1'b1; in1_req = 1'b1;
      for (int i = 0; i < 4; i++)
         expect_grant($sformatf("t3 g%0d", i), exp3[i], exp3[i][1] ? 3'd2 : 3'd3,
                      exp3[i][1] ? 16'h0F0F : 16'hF0F0, (i == 3) ? 3'b011 : 3'b000);
      tick();
      check("t3 count", 32'(wr_count), 32'd8);
      // backpressure, post-capture data change, and a short-lived in1 request
      bank_ready = 1'b0;
      in0_req = 1'b1; in0_addr = 3'd3; in0_data = 16'h1234;
      expect_grant("t4 in0", 3'b010, 3'd3, 16'h1234, 3'b010);
      in0_addr = 3'd7; in0_data = 16'hBEEF;
      for (int i = 1; i <= 5; i++) begin
         if (i == 1) begin in1_req = 1'b1; in1_addr = 3'd6; in1_data = 16'h5555; end
         if (i == 3) in1_req = 1'b0;
         tick();
         check($sformatf("t4 wr_en c%0d", i), 32'(wr_en), 32'd1);
         check($sformatf("t4 addr c%0d", i), 32'(wr_addr), 32'd3);
         check($sformatf("t4 data c%0d", i), 32'(wr_data), 32'h1234);
         if (i == 5) bank_ready = 1'b1;
      end
      tick();
      check("t4 wr_en off", 32'(wr_en), 32'd0);
      check("t4 count", 32'(wr_count), 32'd9);
      seen = 3'b000;
      for (int i = 0; i < 4; i++) begin
         tick();
         seen |= gnt;
      end
      check("t4 dropped req not granted", 32'(seen), 32'd0);
      // reset in the middle of a stalled write with in1 pending
      bank_ready = 1'b0;
      c_req = 1'b1;   c_addr = 3'd1;   c_data = 16'hAAAA;
      in1_req = 1'b1; in1_addr = 3'd6; in1_data = 16'h5555;
      expect_grant("t5 c", 3'b100, 3'd1, 16'hAAAA, 3'b100);
      rst = 1'b1;
      tick();
      check("t5 gnt", 32'(gnt), 32'd0);
      check("t5 wr_en", 32'(wr_en), 32'd0);
      check("t5 wr_addr", 32'(wr_addr), 32'd0);
      check("t5 wr_data", 32'(wr_data), 32'd0);
      check("t5 busy", 32'(busy), 32'd0);
      check("t5 count", 32'(wr_count), 32'd0);
      rst = 1'b0; bank_ready = 1'b1;
      expect_grant("t5 in1", 3'b001, 3'd6, 16'h5555, 3'b001);
      tick();
      check("t5 count after", 32'(wr_count), 32'd1);
      // 256 writes wrap the counter
      rst = 1'b1;
      tick();
      rst = 1'b0;
      c_req = 1'b1; c_addr = 3'd4; c_data = 16'h0001;
      gc = 0; n = 0;
      while (gc < 256 && n < 2000) begin
         tick();
         n++;
         if (c_gnt) begin
            gc++;
            if (gc == 256) c_req = 1'b0;
         end
      end
      check("t6 grants", gc, 256);
      check("t6 count 255", 32'(wr_count), 32'd255);
      tick();
      tick();
      check("t6 count wrap", 32'(wr_count), 32'd0);
      check("t6 idle", 32'(busy), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
